// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared opcode, funct3 and state definitions for the load/store unit
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and sign/zero-extends a load from a 32-bit data word
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{off_i, 3'b000} +: 8];
    half_v = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
      F3_H:    data_o = {{16{half_v[15]}}, half_v};
      F3_BU:   data_o = {24'b0, byte_v};
      F3_HU:   data_o = {16'b0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between execute and the data memory port
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            load_valid_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misaligned_o,
  output logic            error_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] addr_q, wdata_q, load_data_q;
  logic [3:0]      be_q;
  logic [2:0]      f3_q;
  logic            we_q, load_valid_q, misaligned_q, error_q;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            is_load, is_store, mem_op, legal, misal, accept, timeout;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, ext_data;

  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

  always_comb begin
    opcode   = instr_i[6:0];
    f3       = instr_i[14:12];
    is_load  = (opcode == OPC_LOAD);
    is_store = (opcode == OPC_STORE);
    mem_op   = is_load | is_store;
    legal    = f3_legal(f3, is_store);
    be_d     = 4'b1111;
    wdata_d  = store_data_i;
    misal    = 1'b0;
    // Low two funct3 bits give the access size for every legal encoding.
    case (f3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data_i[15:0]}};
        misal   = addr_i[0];
      end
      default: begin
        misal = |addr_i[1:0];
      end
    endcase
    accept  = (state_q == ST_IDLE) && valid_i && mem_op && legal && !misal;
    timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  lsu_load_align u_align (
    .rdata_i  (mem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      be_q         <= '0;
      f3_q         <= '0;
      we_q         <= 1'b0;
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
      error_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i && mem_op) begin
            if (!legal) begin
              error_q <= 1'b1;
            end else if (misal) begin
              misaligned_q <= 1'b1;
            end else begin
              addr_q  <= addr_i;
              be_q    <= be_d;
              wdata_q <= wdata_d;
              f3_q    <= f3;
              we_q    <= is_store;
              cnt_q   <= '0;
              state_q <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_gnt_i) begin
            if (we_q) begin
              state_q <= ST_DONE;
            end else if (mem_rvalid_i) begin
              load_data_q  <= ext_data;
              load_valid_q <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (timeout) begin
            error_q <= 1'b1;
            if (!we_q) begin
              load_data_q  <= '0;
              load_valid_q <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_rvalid_i) begin
            load_data_q  <= ext_data;
            load_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (timeout) begin
            error_q      <= 1'b1;
            load_data_q  <= '0;
            load_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req_o    = (state_q == ST_REQ);
  assign stall_o      = ~rst & (accept | (state_q == ST_REQ) | (state_q == ST_WAIT));
  assign mem_we_o     = we_q;
  assign mem_addr_o   = {addr_q[XLEN-1:2], 2'b00};
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;
  assign misaligned_o = misaligned_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl against a behavioural model
module tb_lsu_ctrl;

  localparam int TO = 16;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] ALU = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] instr_i, addr_i, store_data_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, load_valid_o, misaligned_o, error_o;
  logic [31:0] load_data_o;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .misaligned_o(misaligned_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ld = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp_v);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << (f3 & 3'd3);
  endfunction

  function automatic bit is_legal(input bit st, input logic [2:0] f3);
    if (st) return f3 <= 3'd2;
    return f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    m = ((32'h1 << size_of(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (size_of(f3) == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v, m;
    int sz;
    sz = size_of(f3);
    if (sz == 4) return rd;
    v = rd >> (8 * int'(a[1:0]));
    m = (32'h1 << (8 * sz)) - 1;
    v = v & m;
    if (f3 < 3'd4 && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  // Runs one instruction from IDLE; gd = extra REQ cycles before gnt, rd = cycles from gnt to rvalid (<0: never).
  task automatic do_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int gd, input int rd, input logic [31:0] rdata);
    bit is_ld, is_st, mem, leg, mis, timed;
    int nrw, stalls;
    is_ld = (opc == LD);
    is_st = (opc == ST);
    mem   = is_ld || is_st;
    leg   = is_legal(is_st, f3);
    mis   = leg && ((int'(a[1:0]) % size_of(f3)) != 0);
    valid_i      = 1'b1;
    instr_i      = {17'($urandom), f3, 5'($urandom), opc};
    addr_i       = a;
    store_data_i = sd;
    #1;
    if (!mem || !leg || mis) begin
      check("idle_stall", stall_o, 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check("misaligned", misaligned_o, mem && leg && mis);
      check("illegal_err", error_o, mem && !leg);
      check("no_req", mem_req_o, 0);
      check("hold_data", load_data_o, exp_ld);
      @(posedge clk); #1;
      check("pulse_end", misaligned_o | error_o, 0);
      return;
    end
    stalls = int'(stall_o);
    timed  = is_ld ? (rd < 0 || gd + 1 + rd > TO) : (gd + 1 > TO);
    nrw    = timed ? TO : (is_ld ? gd + 1 + rd : gd + 1);
    @(posedge clk); #1;
    for (int c = 0; c < nrw; c++) begin
      check("req", mem_req_o, c <= gd);
      if (c <= gd) begin
        check("addr", mem_addr_o, {a[31:2], 2'b00});
        check("be", mem_be_o, model_be(f3, a));
        check("we", mem_we_o, is_st);
        if (is_st) check("wdata", mem_wdata_o, model_wdata(f3, sd));
      end
      stalls += int'(stall_o);
      mem_gnt_i    = (c == gd);
      mem_rvalid_i = is_ld && rd >= 0 && (c == gd + rd);
      mem_rdata_i  = mem_rvalid_i ? rdata : $urandom;
      @(posedge clk); #1;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
    end
    if (is_ld) exp_ld = timed ? 32'h0 : model_load(f3, a, rdata);
    check("stall_cycles", stalls, 1 + nrw);
    check("done_stall", stall_o, 0);
    check("done_req", mem_req_o, 0);
    check("load_valid", load_valid_o, is_ld);
    check("timeout_err", error_o, timed);
    check("load_data", load_data_o, exp_ld);
    valid_i = 1'b0;
    if (timed) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hA5A5_5A5A;
    end
    @(posedge clk); #1;
    check("idle_lv", load_valid_o, 0);
    check("idle_stall2", stall_o, 0);
    if (timed) begin
      @(posedge clk); #1;
      mem_rvalid_i = 1'b0;
      check("late_rvalid_lv", load_valid_o, 0);
      check("late_rvalid_data", load_data_o, exp_ld);
    end
  endtask

  initial begin
    logic [6:0] opc;
    rst = 1'b1; valid_i = 1'b0; instr_i = '0; addr_i = '0; store_data_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_lv", load_valid_o, 0);
    check("rst_data", load_data_o, 0);
    check("rst_err", {misaligned_o, error_o, mem_we_o}, 0);
    check("rst_addr", mem_addr_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(LD, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    do_op(LD, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FFFF7F);
    do_op(LD, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FFFF7F);
    do_op(LD, 3'b101, 32'h102, 32'h0, 0, 1, 32'h80FFFF7F);
    do_op(ST, 3'b000, 32'h201, 32'h12345678, 2, 0, 32'h0);
    do_op(LD, 3'b010, 32'h102, 32'h0, 0, 1, 32'h0);
    do_op(LD, 3'b011, 32'h100, 32'h0, 0, 1, 32'h0);
    do_op(ST, 3'b100, 32'h100, 32'h0, 0, 1, 32'h0);
    do_op(LD, 3'b010, 32'h300, 32'h0, 0, -1, 32'h0);

    // Reset while waiting for load data.
    valid_i = 1'b1; instr_i = {17'h0, 3'b010, 5'h1, LD}; addr_i = 32'h400;
    @(posedge clk); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    mem_gnt_i = 1'b0;
    check("wait_stall", stall_o, 1);
    rst = 1'b1;
    #1;
    exp_ld = 32'h0;
    check("arst_stall", stall_o, 0);
    check("arst_req", mem_req_o, 0);
    check("arst_data", load_data_o, 0);
    check("arst_pulses", {load_valid_o, misaligned_o, error_o}, 0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid_i = 1'b0;
    check("post_rst_lv", load_valid_o, 0);
    check("post_rst_stall", stall_o, 0);
    do_op(LD, 3'b010, 32'h404, 32'h0, 0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       opc = ALU;
        1, 2, 3, 4: opc = ST;
        default: opc = LD;
      endcase
      do_op(opc, 3'($urandom_range(0, 7)), $urandom, $urandom,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencer between the execute stage and the data memory port. Takes the registered instruction and ALU-computed address from execute, issues one memory transaction per load/store over a req/gnt/rvalid handshake, and stalls the pipeline until the access completes. It formats store byte-lanes and sign/zero-extends load data. Misaligned or illegal accesses are flagged without a bus transaction.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT before abort; >=2
XLEN, 32, data/address width; only 32 supported

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  1  instr_i/addr_i/store_data_i valid this cycle
instr_i  input  32  instruction at execute output; held by upstream while stall_o=1
addr_i  input  32  effective address (rs1+imm) from execute
store_data_i  input  32  rs2 value for stores
mem_req_o  output  1  memory request
mem_we_o  output  1  1=store, 0=load
mem_addr_o  output  32  word-aligned address {addr[31:2],2'b00}
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  lane-replicated store data
mem_gnt_i  input  1  request accepted
mem_rvalid_i  input  1  load data valid
mem_rdata_i  input  32  load data word
stall_o  output  1  hold upstream pipeline
load_valid_o  output  1  one-cycle pulse, load_data_o valid
load_data_o  output  32  extended load result
misaligned_o  output  1  one-cycle pulse, misaligned access
error_o  output  1  one-cycle pulse, illegal funct3 or timeout

Behaviour:
- Decode: opcode 0000011 = load, 0100011 = store; funct3 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only). Any other funct3 on a mem opcode is illegal.
- Reset (async, any state): state=IDLE, timeout counter=0, all outputs 0, captured regs 0. An outstanding response is dropped. mem_rvalid_i in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, valid_i with a mem op:
  - Aligned and legal: capture addr, be, wdata, funct3, we. stall_o=1 combinationally. Go to REQ.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): misaligned_o=1 next cycle (registered pulse). No request, no stall. Stay IDLE.
  - Illegal funct3: error_o pulse, same rules as misaligned.
- REQ: mem_req_o=1, stall_o=1; address, be, wdata and we are stable until granted.
  - gnt, store: go to DONE.
  - gnt, load, no rvalid: go to WAIT.
  - gnt and rvalid in the same cycle (load): capture data, go to DONE.
- WAIT: stall_o=1, mem_req_o=0. On rvalid: capture extended data, go to DONE.
- DONE: stall_o=0. load_valid_o=1 for loads only. Upstream advances this cycle; instr_i is ignored here. Return to IDLE.
- Timeout: counter clears on entering REQ and increments each REQ/WAIT cycle. At TIMEOUT_CYCLES: error_o pulse, load_data_o=0, go to DONE with load_valid_o=1 for loads. A late rvalid is ignored.
- Store lanes:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: wdata=rs2, be=4'b1111.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]. B/H sign-extend, BU/HU zero-extend, W passes through.
- Latency, zero-wait memory (gnt first REQ cycle, rvalid next cycle):
  - Load: stall_o high 3 cycles (IDLE, REQ, WAIT), load_valid_o in cycle 4.
  - Store: stall_o high 2 cycles.
- load_data_o holds its value until the next load completes.

Decomposition:
- Shared package lsu_pkg: OPC_LOAD/OPC_STORE constants, funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU), lsu_state_t enum.
- One sub-module: lsu_load_align, combinational (rdata, addr[1:0], funct3 -> 32-bit extended result). It is reused by the writeback path.

Test Plan:
- LW addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> mem_addr_o=0x100, be=1111, we=0; stall 3 cycles; load_valid_o=1, load_data_o=0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_FF7F -> load_data_o=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, rs2 0x12345678, gnt after 3 REQ cycles -> req/addr/be held stable, mem_addr_o=0x200, be=0010, wdata=0x78787878; stall 4 cycles; no load_valid_o.
- LW addr 0x102 -> misaligned_o pulses, mem_req_o never asserts, stall_o=0. funct3=011 load -> error_o pulses, no request.
- Load with gnt but no rvalid for TIMEOUT_CYCLES -> error_o pulse, load_data_o=0, return to IDLE. A later rvalid is ignored.
- Assert rst in WAIT -> outputs 0 immediately. Following rvalid ignored. A new LW after release completes normally.
